// File: rtl/ldr_pkg.sv
// Shared types and default widths for the instruction-memory loader.
// The optional checksum (LOADER_CHECKSUM_EN) is handled in the modules that import this.
package ldr_pkg;

    localparam int LDR_ADDR_W = 10;
    localparam int LDR_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        HOLD  = 3'd3,
        RUN   = 3'd4
    } ldr_state_e;

endpackage

// File: rtl/ldr_write_stage.sv
// Registered handshake-to-write stage: one accepted beat becomes one memory write a cycle later.
// With LOADER_CHECKSUM_EN defined it also keeps a running modulo-2**DATA_W sum of accepted words.
module ldr_write_stage
    import ldr_pkg::*;
#(
    parameter int ADDR_W = LDR_ADDR_W,
    parameter int DATA_W = LDR_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [DATA_W-1:0] data,
    output logic              write_instruction,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] ins,
`ifdef LOADER_CHECKSUM_EN
    output logic [DATA_W-1:0] sum,
`endif
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data path is reset as well so ins/addr come up 0 like every other output.
            write_instruction <= 1'b0;
            addr              <= '0;
            ins               <= '0;
            count             <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum               <= '0;
`endif
        end else begin
            write_instruction <= accept;
            if (accept) begin
                addr  <= count[ADDR_W-1:0];
                ins   <= data;
                count <= count + CNT_ONE;
`ifdef LOADER_CHECKSUM_EN
                sum   <= sum + data;
`endif
            end
            if (clear) begin
                count <= '0;
`ifdef LOADER_CHECKSUM_EN
                sum   <= '0;
`endif
            end
        end
    end

endmodule

// File: rtl/ins_mem_loader.sv
// Boot/reload sequencer: clears instruction memory, streams a program image in, then releases cpu_rst.
// Optional LOADER_CHECKSUM_EN adds exp_sum and aborts to IDLE when the streamed image sum disagrees.
module ins_mem_loader
    import ldr_pkg::*;
#(
    parameter int ADDR_W     = LDR_ADDR_W,
    parameter int DATA_W     = LDR_DATA_W,
    parameter int CLR_CYCLES = 2,
    parameter int RST_HOLD   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
`ifdef LOADER_CHECKSUM_EN
    input  logic [DATA_W-1:0] exp_sum,
`endif
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              ins_mem_rst,
    output logic              write_instruction,
    output logic [DATA_W-1:0] ins,
    output logic [ADDR_W-1:0] addr,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [7:0]      CLR_LAST = 8'(CLR_CYCLES - 1);
    localparam logic [7:0]      HLD_LAST = 8'(RST_HOLD - 1);

    ldr_state_e        state;
    logic [7:0]        cnt;
    logic [ADDR_W:0]   last_idx;
    logic [ADDR_W:0]   word_cnt;
    logic              len_ok;
    logic              accept;
    logic              last_beat;
    logic              clear_cnt;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] exp_sum_q;
`endif

    assign len_ok    = (load_len != '0) && (load_len <= DEPTH);
    assign accept    = s_valid & s_ready;
    assign last_beat = accept && (word_cnt == last_idx);
    assign clear_cnt = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last_idx    <= '0;
            s_ready     <= 1'b0;
            ins_mem_rst <= 1'b0;
            cpu_rst     <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            exp_sum_q   <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                // start is only honoured here; while busy it is silently ignored
                IDLE, RUN: begin
                    if (start) begin
                        if (len_ok) begin
                            state       <= CLEAR;
                            last_idx    <= load_len - CNT_ONE;
                            cnt         <= '0;
                            ins_mem_rst <= 1'b1;
                            cpu_rst     <= 1'b1;
                            busy        <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                            exp_sum_q   <= exp_sum;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (cnt == CLR_LAST) begin
                        state       <= LOAD;
                        cnt         <= '0;
                        ins_mem_rst <= 1'b0;
                        s_ready     <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                LOAD: begin
                    if (last_beat) begin
                        state   <= HOLD;
                        cnt     <= '0;
                        s_ready <= 1'b0;
                    end
                end
                HOLD: begin
`ifdef LOADER_CHECKSUM_EN
                    // sum already includes the final word by the first HOLD cycle
                    if (cnt == '0 && sum != exp_sum_q) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else
`endif
                    if (cnt == HLD_LAST) begin
                        state   <= RUN;
                        cpu_rst <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ldr_write_stage #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_write_stage (
        .clk               (clk),
        .rst               (rst),
        .clear             (clear_cnt),
        .accept            (accept),
        .data              (s_data),
        .write_instruction (write_instruction),
        .addr              (addr),
        .ins               (ins),
`ifdef LOADER_CHECKSUM_EN
        .sum               (sum),
`endif
        .count             (word_cnt)
    );

endmodule
